// File: rtl/ysyx_24090013_ifu.sv
// Instruction fetch unit: owns the fetch PC, drives the instruction ROM and presents one
// registered instruction to decode over valid/ready, with redirect, misalign and halt handling.
module ysyx_24090013_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_instrom_ren,
  output logic [31:0] ifu_instrom_addr,
  input  logic [31:0] instrom_ifu_data,
  output logic        ifu_idu_valid,
  output logic [31:0] ifu_idu_inst,
  output logic [31:0] ifu_idu_pc,
  output logic        ifu_idu_misalign,
  input  logic        idu_ifu_ready,
  input  logic        exu_ifu_redirect,
  input  logic [31:0] exu_ifu_target,
  input  logic        exu_ifu_halt,
  output logic [31:0] ifu_fetch_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StFault, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_r_q, pc_r_d;
  logic        mis_q, mis_d;
  logic        fault_pend_q, fault_pend_d;
  logic [31:0] cnt_q, cnt_d;

  logic slot_free;
  logic fetch;
  logic target_mis;
  logic handshake;

  assign slot_free  = !valid_q || idu_ifu_ready;
  assign target_mis = exu_ifu_target[1:0] != 2'b00;
  assign handshake  = valid_q && idu_ifu_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; halt beats redirect, and only reset leaves HALT
  always_comb begin
    state_d = state_q;
    if (exu_ifu_halt) begin
      state_d = StHalt;
    end else if (exu_ifu_redirect && state_q != StHalt) begin
      state_d = target_mis ? StFault : StRun;
    end else if (state_q == StBoot) begin
      state_d = StRun;
    end
  end

  // FSM: outputs
  always_comb begin
    fetch = (state_q == StRun) && slot_free && !exu_ifu_redirect && !exu_ifu_halt;
    ifu_instrom_ren = fetch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      inst_q       <= 32'h0;
      pc_r_q       <= 32'h0;
      mis_q        <= 1'b0;
      fault_pend_q <= 1'b0;
      cnt_q        <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      inst_q       <= inst_d;
      pc_r_q       <= pc_r_d;
      mis_q        <= mis_d;
      fault_pend_q <= fault_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    inst_d       = inst_q;
    pc_r_d       = pc_r_q;
    mis_d        = mis_q;
    fault_pend_d = fault_pend_q;
    cnt_d        = handshake ? cnt_q + 32'd1 : cnt_q;

    if (exu_ifu_halt) begin
      valid_d      = 1'b0;
      fault_pend_d = 1'b0;
    end else if (exu_ifu_redirect) begin
      valid_d      = 1'b0;
      pc_d         = exu_ifu_target;
      fault_pend_d = target_mis && (state_q != StHalt);
    end else if (state_q == StFault && fault_pend_q) begin
      // The fault is reported once, as a pseudo-instruction at the bad target.
      valid_d      = 1'b1;
      inst_d       = 32'h0;
      pc_r_d       = pc_q;
      mis_d        = 1'b1;
      fault_pend_d = 1'b0;
    end else if (fetch) begin
      valid_d = 1'b1;
      inst_d  = instrom_ifu_data;
      pc_r_d  = pc_q;
      mis_d   = 1'b0;
      pc_d    = pc_q + 32'd4;
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  assign ifu_instrom_addr = pc_q;
  assign ifu_idu_valid    = valid_q;
  assign ifu_idu_inst     = inst_q;
  assign ifu_idu_pc       = pc_r_q;
  assign ifu_idu_misalign = mis_q;
  assign ifu_fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_ysyx_24090013_ifu.sv
// Bench for ysyx_24090013_ifu: a queue-based fetch model checked every cycle, plus directed
// literal checks, and a second instance at RESET_PC=FFFFFFFC for PC wrap.
module tb_ysyx_24090013_ifu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ready, redirect, halt;
  logic [31:0] target;
  logic        ren, valid, mis;
  logic [31:0] addr, rdata, inst, ipc, cnt;

  logic        rst1_n, ready1;
  logic        ren1, valid1, mis1;
  logic [31:0] addr1, rdata1, inst1, ipc1, cnt1;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  assign rdata  = rom(addr);
  assign rdata1 = rom(addr1);

  ysyx_24090013_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_instrom_ren(ren), .ifu_instrom_addr(addr), .instrom_ifu_data(rdata),
    .ifu_idu_valid(valid), .ifu_idu_inst(inst), .ifu_idu_pc(ipc), .ifu_idu_misalign(mis),
    .idu_ifu_ready(ready), .exu_ifu_redirect(redirect), .exu_ifu_target(target),
    .exu_ifu_halt(halt), .ifu_fetch_cnt(cnt)
  );

  ysyx_24090013_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .ifu_instrom_ren(ren1), .ifu_instrom_addr(addr1), .instrom_ifu_data(rdata1),
    .ifu_idu_valid(valid1), .ifu_idu_inst(inst1), .ifu_idu_pc(ipc1), .ifu_idu_misalign(mis1),
    .idu_ifu_ready(ready1), .exu_ifu_redirect(1'b0), .exu_ifu_target(32'h0),
    .exu_ifu_halt(1'b0), .ifu_fetch_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, fetch PC, a 0/1-deep slot queue and the accept count.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mis;
  } slot_t;

  localparam int MBoot = 0, MRun = 1, MFault = 2, MHalt = 3;
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_fault_owed;
  slot_t       m_slot[$];

  task automatic model_reset();
    m_mode = MBoot;
    m_pc = 32'h8000_0000;
    m_cnt = 32'h0;
    m_fault_owed = 1'b0;
    m_slot.delete();
  endtask

  function automatic bit model_fetch();
    return rst_n && m_mode == MRun && (m_slot.size() == 0 || ready) && !redirect && !halt;
  endfunction

  task automatic model_step();
    bit accepted, can_fetch;
    accepted  = m_slot.size() > 0 && ready;
    can_fetch = model_fetch();
    if (accepted) m_cnt = m_cnt + 32'd1;
    if (halt) begin
      m_slot.delete();
      m_mode = MHalt;
      m_fault_owed = 1'b0;
    end else if (redirect) begin
      m_slot.delete();
      m_pc = target;
      m_fault_owed = 1'b0;
      if (m_mode != MHalt) begin
        if (target % 4 != 0) begin
          m_mode = MFault;
          m_fault_owed = 1'b1;
        end else begin
          m_mode = MRun;
        end
      end
    end else begin
      if (accepted) void'(m_slot.pop_front());
      if (m_mode == MFault && m_fault_owed) begin
        m_slot.push_back('{inst: 32'h0, pc: m_pc, mis: 1'b1});
        m_fault_owed = 1'b0;
      end else if (can_fetch) begin
        m_slot.push_back('{inst: rom(m_pc), pc: m_pc, mis: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (m_mode == MBoot) m_mode = MRun;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: outputs are sampled mid-cycle, away from the active edge.
  initial begin
    @(negedge clk);
    forever begin
      chk("ren", {31'b0, ren}, {31'b0, model_fetch()});
      chk("addr", addr, m_pc);
      chk("valid", {31'b0, valid}, {31'b0, m_slot.size() > 0});
      chk("fetch_cnt", cnt, m_cnt);
      if (m_slot.size() > 0) begin
        chk("inst", inst, m_slot[0].inst);
        chk("pc", ipc, m_slot[0].pc);
        chk("misalign", {31'b0, mis}, {31'b0, m_slot[0].mis});
      end
      @(negedge clk);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    ready = 1'b1; ready1 = 1'b1;
    redirect = 1'b0; halt = 1'b0; target = 32'h0;
    tick(); tick();
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_ren", {31'b0, ren}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_addr", addr, 32'h8000_0000);

    // Boot: first ROM access one cycle after the BOOT->RUN edge.
    rst_n = 1'b1;
    chk("boot_ren", {31'b0, ren}, 32'd0);
    tick();
    chk("first_ren", {31'b0, ren}, 32'd1);
    chk("first_addr", addr, 32'h8000_0000);
    tick();
    chk("w0_valid", {31'b0, valid}, 32'd1);
    chk("w0_pc", ipc, 32'h8000_0000);
    chk("w0_inst", inst, 32'h9357_0000);
    chk("w0_addr", addr, 32'h8000_0004);
    tick();
    chk("w1_pc", ipc, 32'h8000_0004);
    chk("w1_cnt", cnt, 32'd1);

    // Backpressure: slot 80000004 held for three cycles.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc", ipc, 32'h8000_0004);
      chk("bp_ren", {31'b0, ren}, 32'd0);
      chk("bp_addr", addr, 32'h8000_0008);
    end
    ready = 1'b1;
    tick();
    chk("rel_pc", ipc, 32'h8000_0008);
    chk("rel_inst", inst, 32'h9357_0008);
    tick();
    chk("cnt3", cnt, 32'd3);

    // Redirect under backpressure drops the slot.
    ready = 1'b0;
    redirect = 1'b1; target = 32'h8000_0100;
    tick();
    redirect = 1'b0; ready = 1'b1;
    chk("redir_valid", {31'b0, valid}, 32'd0);
    chk("redir_addr", addr, 32'h8000_0100);
    tick();
    chk("redir_w0", ipc, 32'h8000_0100);
    tick();
    chk("redir_w1", ipc, 32'h8000_0104);

    // Misaligned redirect: one fault slot, no fetch until an aligned redirect.
    ready = 1'b0;
    redirect = 1'b1; target = 32'h8000_0102;
    tick();
    redirect = 1'b0;
    chk("mis_gap_valid", {31'b0, valid}, 32'd0);
    tick();
    chk("mis_valid", {31'b0, valid}, 32'd1);
    chk("mis_flag", {31'b0, mis}, 32'd1);
    chk("mis_pc", ipc, 32'h8000_0102);
    chk("mis_inst", inst, 32'h0);
    chk("mis_ren", {31'b0, ren}, 32'd0);
    tick();
    ready = 1'b1;
    tick();
    chk("mis_taken", {31'b0, valid}, 32'd0);
    tick();
    chk("mis_no_ren", {31'b0, ren}, 32'd0);
    redirect = 1'b1; target = 32'h8000_0200;
    tick();
    redirect = 1'b0;
    chk("resume_addr", addr, 32'h8000_0200);
    tick();
    chk("resume_pc", ipc, 32'h8000_0200);
    chk("resume_mis", {31'b0, mis}, 32'd0);
    tick();

    // Halt and redirect together: halt wins, fetching stops for good.
    halt = 1'b1; redirect = 1'b1; target = 32'h8000_0300;
    tick();
    halt = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_ren", {31'b0, ren}, 32'd0);
      chk("halt_valid", {31'b0, valid}, 32'd0);
    end

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("pre_rst_valid", {31'b0, valid}, 32'd1);
    chk("pre_rst_cnt", cnt, 32'd2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, valid}, 32'd0);
    chk("async_cnt", cnt, 32'd0);
    chk("async_ren", {31'b0, ren}, 32'd0);
    tick();

    // PC wrap on the second instance.
    rst1_n = 1'b1;
    tick();
    chk("wrap_ren", {31'b0, ren1}, 32'd1);
    chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc0", ipc1, 32'hFFFF_FFFC);
    chk("wrap_inst0", inst1, 32'hECA8_FFFC);
    chk("wrap_addr1", addr1, 32'h0);
    tick();
    chk("wrap_pc1", ipc1, 32'h0);
    chk("wrap_inst1", inst1, 32'h1357_0000);
    chk("wrap_cnt", cnt1, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
